// File: rtl/approx_adder_sched.sv
// Round-robin scheduler sharing one fixed-latency approximate adder between two requesters.
// Each result is checked against an exact sum, and the counters track operations and errors.
module approx_adder_sched #(
  parameter int W       = 16,
  parameter int ADD_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [W-1:0]     rsp0_sum,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [W-1:0]     rsp1_sum,
  output logic             rsp1_err,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  output logic             add_cin,
  input  logic [W-1:0]     add_sum,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0]       LAT     = 4'(ADD_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t         state;
  logic           rr_ptr;
  logic           gnt_id;
  logic [3:0]     wait_cnt;
  logic           grant;
  logic           accept;
  logic           rsp_hs;
  logic           cur_err;
  logic [W-1:0]   exact;

  // Ready is withheld during reset so a requester never sees a handshake that reset discards.
  always_comb begin
    grant      = rr_ptr ? req1_valid : !req0_valid;
    accept     = (state == IDLE) && !rst && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    exact      = add_a + add_b + W'(add_cin);
    rsp_hs     = gnt_id ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);
    cur_err    = gnt_id ? rsp1_err : rsp0_err;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      gnt_id     <= 1'b0;
      wait_cnt   <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_cin    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp0_sum   <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_sum   <= '0;
      rsp1_err   <= 1'b0;
      op_count   <= '0;
      err_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            add_a    <= grant ? req1_a : req0_a;
            add_b    <= grant ? req1_b : req0_b;
            add_cin  <= grant ? req1_cin : req0_cin;
            gnt_id   <= grant;
            rr_ptr   <= ~grant;
            wait_cnt <= LAT;
            state    <= WAIT;
          end
        end
        // The final WAIT cycle is the one in which the adder output is valid.
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) begin
            if (gnt_id) begin
              rsp1_valid <= 1'b1;
              rsp1_sum   <= add_sum;
              rsp1_err   <= (add_sum != exact);
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_sum   <= add_sum;
              rsp0_err   <= (add_sum != exact);
            end
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            if (gnt_id) rsp1_valid <= 1'b0;
            else        rsp0_valid <= 1'b0;
            if (op_count != CNT_MAX)             op_count  <= op_count + 1'b1;
            if (cur_err && err_count != CNT_MAX) err_count <= err_count + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
